// File: rtl/ps2_key_tracker_if.sv
// Signal bundle between the PS/2 pins, the key tracker and the seven-segment display stage.
interface ps2_key_tracker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ps2_clk;
  logic             ps2_dat;
  logic [7:0]       key_code;
  logic             is_press;
  logic [CNT_W-1:0] count;
  logic             byte_vld;
  logic             frame_err;

  modport master (
    input  ps2_clk, ps2_dat,
    output key_code, is_press, count, byte_vld, frame_err
  );

  modport slave (
    output ps2_clk, ps2_dat,
    input  key_code, is_press, count, byte_vld, frame_err
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises 11-bit frames and tracks make/break state.
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose parity bit is not odd.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               clrn,
  ps2_key_tracker_if.master  bus
);

  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IDX_W  = 4;
  localparam logic [7:0]  B_EXT  = 8'hE0;
  localparam logic [7:0]  B_BRK  = 8'hF0;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit          PAR_EN = 1'b1;
`else
  localparam bit          PAR_EN = 1'b0;
`endif

  typedef enum logic {S_MAKE, S_BREAK} state_e;

  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [2:0]       dat_sync_q, dat_sync_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       shift_q, shift_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_err_q, pend_err_d;
  logic [7:0]       pend_byte_q, pend_byte_d;
  state_e           state_q, state_d;
  logic [7:0]       key_q, key_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frame_err_q, frame_err_d;

  logic             fall_c;
  logic             dat_c;
  logic             parity_ok_c;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '0;
      dat_sync_q  <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      to_q        <= '0;
      pend_vld_q  <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_byte_q <= '0;
      state_q     <= S_MAKE;
      key_q       <= '0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      to_q        <= to_d;
      pend_vld_q  <= pend_vld_d;
      pend_err_q  <= pend_err_d;
      pend_byte_q <= pend_byte_d;
      state_q     <= state_d;
      key_q       <= key_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], bus.ps2_clk};
    dat_sync_d  = {dat_sync_q[1:0], bus.ps2_dat};
    idx_d       = idx_q;
    shift_d     = shift_q;
    to_d        = to_q;
    pend_vld_d  = 1'b0;
    pend_err_d  = 1'b0;
    pend_byte_d = pend_byte_q;
    state_d     = state_q;
    key_d       = key_q;
    press_d     = press_q;
    cnt_d       = cnt_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;

    fall_c      = (clk_sync_q[2:1] == 2'b10);
    dat_c       = dat_sync_q[2];
    parity_ok_c = !PAR_EN || (^shift_q[9:1]);

    // Deserialiser: bit 10 is the stop bit, checked live rather than stored
    if (fall_c) begin
      to_d = '0;
      if (idx_q == IDX_W'(10)) begin
        idx_d = '0;
        if (!shift_q[0] && dat_c && parity_ok_c) begin
          pend_vld_d  = 1'b1;
          pend_byte_d = shift_q[8:1];
        end else begin
          pend_err_d  = 1'b1;
        end
      end else begin
        shift_d[idx_q] = dat_c;
        idx_d          = idx_q + IDX_W'(1);
      end
    end else if (idx_q != '0) begin
      to_d = to_q + TO_W'(1);
      if (to_d == TO_W'(TIMEOUT_CYC)) begin
        idx_d = '0;
      end
    end

    // Key state machine, one cycle behind the stop-bit sample
    if (pend_err_q) begin
      frame_err_d = 1'b1;
    end else if (pend_vld_q) begin
      byte_vld_d = 1'b1;
      unique case (state_q)
        S_MAKE: begin
          if (pend_byte_q == B_BRK) begin
            state_d = S_BREAK;
          end else if (pend_byte_q != B_EXT && !(press_q && pend_byte_q == key_q)) begin
            key_d   = pend_byte_q;
            press_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (pend_byte_q != B_BRK && pend_byte_q != B_EXT) begin
            if (pend_byte_q == key_q) begin
              press_d = 1'b0;
            end
            state_d = S_MAKE;
          end
        end
        default: state_d = S_MAKE;
      endcase
    end
  end

  assign bus.key_code  = key_q;
  assign bus.is_press  = press_q;
  assign bus.count     = cnt_q;
  assign bus.byte_vld  = byte_vld_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_ps2_key_tracker;

  localparam int unsigned TO_CYC = 100;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic       press;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic clrn;
  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  ps2_key_tracker_if #(.CNT_W(8)) bus ();

  ps2_key_tracker #(.TIMEOUT_CYC(TO_CYC), .CNT_W(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] frame(input logic [7:0] b);
    frame = {1'b1, ~^b, b, 1'b0};
  endfunction

  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    if (clrn && (bus.byte_vld || bus.frame_err)) begin
      n_chk++;
      if (bus.byte_vld && bus.frame_err) begin
        $display("FAIL both_pulses: byte_vld and frame_err high together at %0t", $time);
      end else if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: byte_vld=%0b frame_err=%0b with nothing expected at %0t",
                 bus.byte_vld, bus.frame_err, $time);
      end else begin
        e = q.pop_front();
        if (bus.frame_err == e.err && bus.key_code == e.code &&
            bus.is_press == e.press && bus.count == e.cnt) begin
          n_pass++;
        end else begin
          $display("FAIL pulse_check: got err=%0b code=%h press=%0b cnt=%h, want err=%0b code=%h press=%0b cnt=%h",
                   bus.frame_err, bus.key_code, bus.is_press, bus.count,
                   e.err, e.code, e.press, e.cnt);
        end
      end
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_dat = bits[i];
      repeat (2) @(posedge clk);
      bus.ps2_clk = 1'b0;
      repeat (4) @(posedge clk);
      bus.ps2_clk = 1'b1;
      repeat (2) @(posedge clk);
    end
    bus.ps2_dat = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL %s_timeout: %0d expected pulses never seen", name, q.size());
      q.delete();
    end
  endtask

  task automatic send_raw(input logic [10:0] bits, input bit err, input logic [7:0] code,
                          input logic press, input logic [7:0] cnt, input string name);
    exp_t e;
    e.err = err; e.code = code; e.press = press; e.cnt = cnt;
    q.push_back(e);
    send_bits(bits, 11);
    wait_drain(name);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] code,
                           input logic press, input logic [7:0] cnt, input string name);
    send_raw(frame(b), 1'b0, code, press, cnt, name);
  endtask

  task automatic check_outs(input string name, input logic [7:0] code,
                            input logic press, input logic [7:0] cnt);
    n_chk++;
    if (bus.key_code == code && bus.is_press == press && bus.count == cnt &&
        !bus.byte_vld && !bus.frame_err) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got code=%h press=%0b cnt=%h vld=%0b err=%0b, want code=%h press=%0b cnt=%h vld=0 err=0",
               name, bus.key_code, bus.is_press, bus.count, bus.byte_vld, bus.frame_err,
               code, press, cnt);
    end
  endtask

  initial begin
    logic [10:0] bad;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 8'h00, 1'b0, 8'h00);
    clrn = 1'b1;
    repeat (5) @(posedge clk);

    // Single press
    send_byte(8'h1C, 8'h1C, 1'b1, 8'h01, "press_1c");
    // Typematic repeats then release
    send_byte(8'h1C, 8'h1C, 1'b1, 8'h01, "repeat_1");
    send_byte(8'h1C, 8'h1C, 1'b1, 8'h01, "repeat_2");
    send_byte(8'h1C, 8'h1C, 1'b1, 8'h01, "repeat_3");
    send_byte(8'hF0, 8'h1C, 1'b1, 8'h01, "brk_f0");
    send_byte(8'h1C, 8'h1C, 1'b0, 8'h01, "release_1c");
    // Rollover: release of the untracked key is ignored
    send_byte(8'h1C, 8'h1C, 1'b1, 8'h02, "press_1c_again");
    send_byte(8'h32, 8'h32, 1'b1, 8'h03, "press_32");
    send_byte(8'hF0, 8'h32, 1'b1, 8'h03, "brk_f0_b");
    send_byte(8'h1C, 8'h32, 1'b1, 8'h03, "release_other");
    send_byte(8'h32, 8'h32, 1'b1, 8'h03, "back_in_make");
    // Extended key
    send_byte(8'hE0, 8'h32, 1'b1, 8'h03, "ext_e0");
    send_byte(8'h75, 8'h75, 1'b1, 8'h04, "press_75");
    send_byte(8'hE0, 8'h75, 1'b1, 8'h04, "ext_e0_b");
    send_byte(8'hF0, 8'h75, 1'b1, 8'h04, "ext_f0");
    send_byte(8'h75, 8'h75, 1'b0, 8'h04, "release_75");

    // Partial frame then idle past the timeout
    send_bits(frame(8'h55), 5);
    repeat (TO_CYC + 10) @(posedge clk);
    send_byte(8'h29, 8'h29, 1'b1, 8'h05, "after_timeout");

    // Bad stop bit and bad start bit
    bad = frame(8'h44);
    bad[10] = 1'b0;
    send_raw(bad, 1'b1, 8'h29, 1'b1, 8'h05, "bad_stop");
    bad = frame(8'h44);
    bad[0] = 1'b1;
    send_raw(bad, 1'b1, 8'h29, 1'b1, 8'h05, "bad_start");

    // Drive the counter up to FF with alternating keys, then wrap
    for (int i = 1; i <= 250; i++) begin
      if (i % 2 == 1) send_byte(8'h1C, 8'h1C, 1'b1, 8'(5 + i), "count_up");
      else            send_byte(8'h32, 8'h32, 1'b1, 8'(5 + i), "count_up");
    end
    send_byte(8'h2A, 8'h2A, 1'b1, 8'h00, "count_wrap");

`ifdef PS2_PARITY_CHECK_EN
    bad = frame(8'h1C);
    bad[9] = ~bad[9];
    send_raw(bad, 1'b1, 8'h2A, 1'b1, 8'h00, "bad_parity");
`endif

    // Reset in the middle of a frame
    send_bits(frame(8'h1C), 5);
    @(posedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("clrn_mid", 8'h00, 1'b0, 8'h00);
    clrn = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(8'h1C, 8'h1C, 1'b1, 8'h01, "after_clrn");

    repeat (20) @(posedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_empty: %0d left, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
